acc_calc_arb: RTL
=================

# acc_calc_arb

Packet-level arbiter that shares one `acc_calc_ip` accumulator core between two AXI-Stream requesters. It grants whole input packets to the core in round-robin order and records each grant's requester ID in an order FIFO. It then routes each core result packet back to the requester that issued the matching input packet. It sits between the two edge-pixel producers and the core's `s00`/`m00` stream ports.

## Interface
- `DATA_WIDTH`, 32, tdata width of all streams (matches core S00/M00 width)
- `ORDER_DEPTH`, 4, number of outstanding packets tracked; power of two, ≥2
- `aclk` in 1: single clock
- `aresetn` in 1: asynchronous, active-low reset
- `s0_axis_tdata/tvalid/tlast` in DATA_WIDTH/1/1, `s0_axis_tready` out 1: requester 0 input packets
- `s1_axis_tdata/tvalid/tlast` in DATA_WIDTH/1/1, `s1_axis_tready` out 1: requester 1 input packets
- `m_acc_tdata/tvalid/tlast` out DATA_WIDTH/1/1, `m_acc_tready` in 1: to core `s00_axis`
- `s_acc_tdata/tvalid/tlast` in DATA_WIDTH/1/1, `s_acc_tready` out 1: from core `m00_axis`
- `m0_axis_tdata/tvalid/tlast` out DATA_WIDTH/1/1, `m0_axis_tready` in 1: results to requester 0
- `m1_axis_tdata/tvalid/tlast` out DATA_WIDTH/1/1, `m1_axis_tready` in 1: results to requester 1

## Operation
- Request FSM states: IDLE, GRANT0, GRANT1.
- IDLE to GRANTn:
  - Requires order FIFO not full and at least one `sX_axis_tvalid`.
  - Round-robin: the requester not granted last wins a tie.
  - After reset, s0 has priority.
  - On the transition, push ID n into the order FIFO and update the last-granted pointer.
- In GRANTn:
  - `m_acc_*` is combinationally driven from `sn_axis_*`.
  - `sn_axis_tready = m_acc_tready`; the other requester's tready is 0.
  - On a beat with `tvalid & tready & tlast`, return to IDLE.
- In IDLE: `m_acc_tvalid = 0`, both `sX_axis_tready = 0`.
- Response path, with order FIFO non-empty and head ID h:
  - `mh_axis_*` is driven from `s_acc_*`; `s_acc_tready = mh_axis_tready`.
  - The other master's tvalid is 0.
  - On a beat with `tvalid & tready & tlast`, pop the FIFO.
- Response path, order FIFO empty: `s_acc_tready = 0`, both `mX_axis_tvalid = 0`. A core beat with no pending entry stalls; this is not legal in normal use.
- Request and response paths run independently.
- A result packet may begin before its input packet's tlast, because the ID is pushed at grant.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Push is gated by full as evaluated before the same-cycle pop, so a full FIFO never grants even if a pop occurs that cycle.
- A packet's length is not checked. Single-beat packets (tvalid & tlast on the first beat) are legal.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM in IDLE, FIFO empty, RR pointer set so that s0 wins.
  - All tvalid and tready outputs are 0; tdata outputs are don't-care.
- Grant latency: tvalid seen in IDLE at cycle t gives GRANTn registered at t+1. The earliest accepted beat is at t+1.
- Data path has zero latency: no register stages on tdata/tvalid/tlast/tready.
- Packet-to-packet gap: one IDLE bubble cycle after each input tlast.
- A requester must hold tvalid/tdata stable until accepted (AXI-Stream rules). The arbiter never withdraws a grant mid-packet.
- Reset mid-packet discards the FSM state and FIFO contents. Upstream logic and the core must be reset in the same reset domain.

## Structure
- Package `acc_calc_pkg` holds:
  - `typedef logic req_id_t` (requester ID)
  - `typedef enum {IDLE, GRANT0, GRANT1} arb_state_e`
  - `localparam NUM_REQ = 2`
- Sub-module `acc_calc_order_fifo`:
  - Synchronous FIFO of `req_id_t`, depth `ORDER_DEPTH`.
  - Signals: push, pop, full, empty, head.
  - Pointer width is `$clog2(ORDER_DEPTH)+1` for the full/empty distinction.
- Top level holds the FSM, RR pointer, request mux and response demux.

## Test plan
- Single request: s0 sends a 4-beat packet 0x10..0x13.
  - `m_acc` shows the same 4 beats with tlast on 0x13.
  - The core echoes 2 beats 0xA0, 0xA1, which appear only on `m0_axis`; `m1_axis_tvalid` stays 0.
- Contention: s0 and s1 are both valid in IDLE right after reset.
  - Grant order is s0, s1, s0, s1 over 4 packets.
  - Results return as m0, m1, m0, m1 in order.
- Backpressure: `m_acc_tready` toggles 1,0,0,1 during a GRANT1 packet.
  - `s1_axis_tready` mirrors it exactly; `s0_axis_tready` stays 0.
  - Data is neither lost nor duplicated.
- FIFO full: with ORDER_DEPTH=4, send 4 packets while holding `s_acc_tvalid = 0`.
  - The 5th pending packet is not granted: FSM stays IDLE and tready is 0.
  - One result pop lets the grant occur on the next cycle.
- Empty FIFO: assert `s_acc_tvalid` with no grants issued.
  - `s_acc_tready` stays 0 and `m0`/`m1` tvalid stay 0.
- Reset mid-packet: assert aresetn low after 2 of 5 beats.
  - All tvalid/tready go to 0 immediately.
  - After release, a new s1 packet is granted normally, with s0 still preferred on a tie.

Source files
------------

// File: rtl/acc_calc_pkg.sv
// Shared types for the acc_calc packet arbiter: requester ID, arbiter state
// encoding and the requester count.
package acc_calc_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/acc_calc_order_fifo.sv
// Order FIFO: remembers which requester owns each packet granted to the core,
// so result packets can be routed back in issue order.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   push_i        - write push_id_i (ignored when full)
//   push_id_i     - requester ID of the packet just granted
//   pop_i         - retire the head entry (ignored when empty)
//   full_o        - no free entry
//   empty_o       - no pending entry
//   head_o        - requester ID of the oldest pending packet
module acc_calc_order_fifo
    import acc_calc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  req_id_t push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_t head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    req_id_t       mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB separates full (wrapped once) from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_id_i;
        end
    end

endmodule

// File: rtl/acc_calc_arb.sv
// Packet-level round-robin arbiter sharing one accumulator core between two
// AXI-Stream requesters, with in-order routing of core results back to the
// requester that issued each input packet.
// Ports:
//   aclk, aresetn          - clock, async active-low reset
//   s0_axis_*, s1_axis_*   - requester input packets
//   m_acc_*                - granted packet stream to the core
//   s_acc_*                - result stream from the core
//   m0_axis_*, m1_axis_*   - results back to requester 0 / 1
module acc_calc_arb
    import acc_calc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ORDER_DEPTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,

    output logic [DATA_WIDTH-1:0] m_acc_tdata,
    output logic                  m_acc_tvalid,
    output logic                  m_acc_tlast,
    input  logic                  m_acc_tready,

    input  logic [DATA_WIDTH-1:0] s_acc_tdata,
    input  logic                  s_acc_tvalid,
    input  logic                  s_acc_tlast,
    output logic                  s_acc_tready,

    output logic [DATA_WIDTH-1:0] m0_axis_tdata,
    output logic                  m0_axis_tvalid,
    output logic                  m0_axis_tlast,
    input  logic                  m0_axis_tready,

    output logic [DATA_WIDTH-1:0] m1_axis_tdata,
    output logic                  m1_axis_tvalid,
    output logic                  m1_axis_tlast,
    input  logic                  m1_axis_tready
);

    arb_state_e state_q, state_d;
    req_id_t    last_q, last_d;
    logic       push;
    req_id_t    push_id;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    req_id_t    head_id;

    // Order FIFO: ID pushed at grant time, popped on each result tlast.
    acc_calc_order_fifo #(
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push_i    (push),
        .push_id_i (push_id),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (head_id)
    );

    // Request FSM and request mux.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        push           = 1'b0;
        push_id        = 1'b0;
        m_acc_tdata    = '0;
        m_acc_tvalid   = 1'b0;
        m_acc_tlast    = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state_q)
            IDLE: begin
                // Full is sampled before any same-cycle pop, so a full FIFO never grants.
                if (!fifo_full) begin
                    if (s0_axis_tvalid && (!s1_axis_tvalid || last_q == 1'b1)) begin
                        state_d = GRANT0;
                        push    = 1'b1;
                        push_id = 1'b0;
                        last_d  = 1'b0;
                    end else if (s1_axis_tvalid) begin
                        state_d = GRANT1;
                        push    = 1'b1;
                        push_id = 1'b1;
                        last_d  = 1'b1;
                    end
                end
            end
            GRANT0: begin
                m_acc_tdata    = s0_axis_tdata;
                m_acc_tvalid   = s0_axis_tvalid;
                m_acc_tlast    = s0_axis_tlast;
                s0_axis_tready = m_acc_tready;
                if (s0_axis_tvalid && m_acc_tready && s0_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            GRANT1: begin
                m_acc_tdata    = s1_axis_tdata;
                m_acc_tvalid   = s1_axis_tvalid;
                m_acc_tlast    = s1_axis_tlast;
                s1_axis_tready = m_acc_tready;
                if (s1_axis_tvalid && m_acc_tready && s1_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response demux: steer core results to the requester at the FIFO head.
    always_comb begin
        m0_axis_tdata  = s_acc_tdata;
        m1_axis_tdata  = s_acc_tdata;
        m0_axis_tlast  = s_acc_tlast;
        m1_axis_tlast  = s_acc_tlast;
        m0_axis_tvalid = 1'b0;
        m1_axis_tvalid = 1'b0;
        s_acc_tready   = 1'b0;
        if (!fifo_empty) begin
            if (head_id == 1'b0) begin
                m0_axis_tvalid = s_acc_tvalid;
                s_acc_tready   = m0_axis_tready;
            end else begin
                m1_axis_tvalid = s_acc_tvalid;
                s_acc_tready   = m1_axis_tready;
            end
        end
    end

    assign pop = s_acc_tvalid && s_acc_tready && s_acc_tlast;

    // Reset leaves last_q = 1 so requester 0 wins the first tie.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule
